// File: rtl/audio_pkg.sv
// Constants and types shared by the SID mixer, the sample feeder and pwm_audio.
// Pure declarations: no latency, no backpressure.
// The PWM period here must agree with pwm_audio's period.
package audio_pkg;

    localparam int          IN_WIDTH_DEF    = 16;
    localparam int          OUT_WIDTH_DEF   = 12;
    localparam int          PWM_PERIOD_CLKS = 4095;
    localparam logic [11:0] MIDSCALE        = 12'h800;

    typedef logic signed [IN_WIDTH_DEF-1:0] sample_t;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// Head entry is visible combinationally; push/pop take effect on the clock edge.
// A push while full is dropped and a pop while empty is ignored.
module audio_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Buffers signed mixer samples and hands one noise-shaped 12-bit sample to pwm_audio per PWM period.
// sample/sample_strobe update one cycle after the period tick; sample then holds for a full period.
// in_ready drops only when the FIFO is full; an empty FIFO at a tick repeats the last sample and flags underrun.
module pwm_sample_feeder
    import audio_pkg::*;
#(
    parameter int IN_WIDTH   = IN_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int PWM_PERIOD = PWM_PERIOD_CLKS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_WIDTH-1:0]          in_sample,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         underrun_clr,
    output logic [OUT_WIDTH-1:0]         sample,
    output logic                         sample_strobe,
    output logic                         underrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

    localparam int SH = IN_WIDTH - OUT_WIDTH;
    localparam int SW = IN_WIDTH + 1;
    localparam int CW = $clog2(PWM_PERIOD);
    localparam logic [OUT_WIDTH-1:0] MID = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [IN_WIDTH-1:0]  MSB = {1'b1, {(IN_WIDTH-1){1'b0}}};

    logic [CW-1:0]       cnt;
    logic                tick;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IN_WIDTH-1:0] head;
    logic [IN_WIDTH-1:0] head_ob;
    logic [SW-1:0]       sum;
    logic [SH-1:0]       err;

    assign tick     = (cnt == CW'(PWM_PERIOD - 1));
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // No bypass: emptiness comes from registered level, so a same-cycle push is never popped.
    assign pop      = tick && !fifo_empty;

    audio_sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (in_sample),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Offset-binary conversion plus the truncated residue from the previous sample.
    assign head_ob = head ^ MSB;
    assign sum     = {1'b0, head_ob} + SW'(err);

    always_ff @(posedge clk) begin
        if (rst) begin
            sample        <= MID;
            sample_strobe <= 1'b0;
            err           <= '0;
        end else begin
            sample_strobe <= pop;
            if (pop) begin
                if (sum[IN_WIDTH]) begin
                    sample <= '1;
                    err    <= '0;
                end else begin
                    sample <= sum[IN_WIDTH-1:SH];
                    err    <= sum[SH-1:0];
                end
            end
        end
    end

    // A new underrun outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (tick && fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed and random checks of pwm_sample_feeder against a queue-based reference model.
module tb_pwm_sample_feeder;
    import audio_pkg::*;

    localparam int P     = 64;
    localparam int DEPTH = 4;
    localparam int IW    = 16;
    localparam int OW    = 12;
    localparam int SH    = IW - OW;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [IW-1:0]            in_sample = '0;
    logic                     in_valid = 1'b0;
    logic                     underrun_clr = 1'b0;
    logic                     in_ready;
    logic [OW-1:0]            sample;
    logic                     sample_strobe;
    logic                     underrun;
    logic [$clog2(DEPTH):0]   fifo_level;

    int n_cmp  = 0;
    int n_fail = 0;

    pwm_sample_feeder #(
        .IN_WIDTH   (IW),
        .OUT_WIDTH  (OW),
        .PWM_PERIOD (P),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_sample     (in_sample),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .underrun_clr  (underrun_clr),
        .sample        (sample),
        .sample_strobe (sample_strobe),
        .underrun      (underrun),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending samples, a cycle count since reset, and the residue.
    logic [IW-1:0] m_q[$];
    logic [OW-1:0] m_log[$];
    int unsigned   m_cyc = 0;
    int unsigned   m_err = 0;
    logic [OW-1:0] m_sample = MIDSCALE;
    logic          m_strobe = 1'b0;
    logic          m_underrun = 1'b0;
    logic          m_tick, m_take, m_set;
    logic [IW-1:0] m_v;
    int unsigned   m_s;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_cyc = 0;
            m_err = 0;
            m_sample = MIDSCALE;
            m_strobe = 1'b0;
            m_underrun = 1'b0;
        end else begin
            m_tick   = ((m_cyc % P) == P - 1);
            m_take   = in_valid && (m_q.size() < DEPTH);
            m_strobe = 1'b0;
            m_set    = 1'b0;
            if (m_tick) begin
                if (m_q.size() > 0) begin
                    m_v = m_q.pop_front();
                    m_s = {16'h0, m_v ^ 16'h8000} + m_err;
                    if (m_s > 32'hFFFF) begin
                        m_sample = '1;
                        m_err = 0;
                    end else begin
                        m_sample = OW'(m_s >> SH);
                        m_err = m_s % (1 << SH);
                    end
                    m_strobe = 1'b1;
                    m_log.push_back(m_sample);
                end else begin
                    m_set = 1'b1;
                end
            end
            if (m_take) m_q.push_back(in_sample);
            if (m_set) m_underrun = 1'b1;
            else if (underrun_clr) m_underrun = 1'b0;
            m_cyc++;
        end
    end

    logic [OW-1:0] d_log[$];
    int            d_time[$];
    int            t_cyc = 0;
    int            t_rel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            t_cyc++;
            if (sample_strobe === 1'b1) begin
                d_log.push_back(sample);
                d_time.push_back(t_cyc);
            end
            chk("sample", 32'(sample), 32'(m_sample));
            chk("strobe", 32'(sample_strobe), 32'(m_strobe));
            chk("underrun", 32'(underrun), 32'(m_underrun));
            chk("level", 32'(fifo_level), m_q.size());
            chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_valid = 1'b0;
        underrun_clr = 1'b0;
        step(5);
        chk("rst_sample", 32'(sample), 32'h800);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_strobe", 32'(sample_strobe), 0);
        rst = 1'b0;
        t_rel = t_cyc;
    endtask

    task automatic push(input logic [IW-1:0] v);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_sample = v;
        for (int k = 0; k < 4 * P && !done; k++) begin
            done = in_ready;
            step(1);
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(done), 1);
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 3 * P * DEPTH && d_log.size() < n; k++) step(1);
        chk("strobe_count", 32'(d_log.size() >= n), 1);
    endtask

    task automatic step_to_phase(input int unsigned ph);
        for (int k = 0; k < 2 * P && (m_cyc % P) != ph; k++) step(1);
    endtask

    initial begin
        int b;

        // Mapping and first-strobe timing.
        reset_dut();
        b = d_log.size();
        push(16'h0000);
        push(16'h7FFF);
        push(16'h8000);
        wait_log(b + 3);
        chk("first_strobe_delay", d_time[b] - t_rel, P);
        chk("map_zero", 32'(d_log[b]), 32'h800);
        chk("map_max", 32'(d_log[b+1]), 32'hFFF);
        chk("map_min", 32'(d_log[b+2]), 32'h000);
        chk("strobe_spacing", d_time[b+1] - d_time[b], P);

        // Noise shaping: a half-LSB input dithers between two codes.
        reset_dut();
        b = d_log.size();
        for (int i = 0; i < 6; i++) push(16'h0008);
        wait_log(b + 6);
        for (int i = 0; i < 6; i++)
            chk("noise_shape", 32'(d_log[b+i]), (i % 2) ? 32'h801 : 32'h800);

        // Saturation at full scale.
        reset_dut();
        b = d_log.size();
        push(16'h7FF8);
        push(16'h7FF8);
        wait_log(b + 2);
        chk("sat_first", 32'(d_log[b]), 32'hFFF);
        chk("sat_clamp", 32'(d_log[b+1]), 32'hFFF);

        // Flow control: five samples against four entries.
        reset_dut();
        for (int i = 0; i < 4; i++) push(IW'(16'h1000 * (i + 1)));
        chk("full_level", 32'(fifo_level), 4);
        chk("full_ready", 32'(in_ready), 0);
        b = d_log.size();
        in_valid = 1'b1;
        in_sample = 16'hC3A5;
        wait_log(b + 1);
        chk("pop_level", 32'(fifo_level), 3);
        chk("pop_ready", 32'(in_ready), 1);
        step(1);
        in_valid = 1'b0;
        chk("refill_level", 32'(fifo_level), 4);

        // Drain, then two empty ticks.
        wait_log(b + 5);
        step(2 * P + 2);
        chk("underrun_set", 32'(underrun), 1);
        chk("underrun_hold", 32'(sample), 32'(m_log[$]));
        chk("underrun_hold_ref", 32'(sample), 32'(d_log[$]));

        step_to_phase(10);
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        chk("underrun_clr", 32'(underrun), 0);

        step_to_phase(P - 1);
        underrun_clr = 1'b1;
        step(1);
        underrun_clr = 1'b0;
        chk("set_wins", 32'(underrun), 1);

        // Mid-operation reset discards buffered samples.
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        chk("pre_rst_level", 32'(fifo_level), 3);
        rst = 1'b1;
        step(1);
        chk("midrst_level", 32'(fifo_level), 0);
        chk("midrst_sample", 32'(sample), 32'h800);

        // Random traffic: a filling phase, then a sparse phase that underruns.
        reset_dut();
        for (int i = 0; i < 6 * P; i++) begin
            in_valid = ($urandom_range(P / 2 - 1, 0) == 0);
            in_sample = IW'($urandom);
            underrun_clr = ($urandom_range(39, 0) == 0);
            step(1);
        end
        for (int i = 0; i < 6 * P; i++) begin
            in_valid = ($urandom_range(2 * P - 1, 0) == 0);
            in_sample = IW'($urandom);
            underrun_clr = ($urandom_range(39, 0) == 0);
            step(1);
        end
        in_valid = 1'b0;
        underrun_clr = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
